// File: rtl/ysyx_23060061_exec_sequencer_pkg.sv
// Shared state encodings and decoder MemRW codes for the NPC execution sequencer.
package ysyx_23060061_exec_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned MEMRW_W = 2;

  typedef enum logic [STATE_W-1:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_IWAIT  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_MREQ   = 3'd3,
    SEQ_MWAIT  = 3'd4,
    SEQ_WB     = 3'd5,
    SEQ_HALT   = 3'd6,
    SEQ_FAULT  = 3'd7
  } seqState_e;

  localparam logic [MEMRW_W-1:0] MEM_NONE = 2'b00;
  localparam logic [MEMRW_W-1:0] MEM_RD   = 2'b10;
  localparam logic [MEMRW_W-1:0] MEM_WR   = 2'b01;
  localparam logic [MEMRW_W-1:0] MEM_ILL  = 2'b11;

  // States that wait on an external bus handshake and are watched for hangs.
  function automatic logic isBusWait(input seqState_e s);
    return (s == SEQ_FETCH) || (s == SEQ_IWAIT) || (s == SEQ_MREQ) || (s == SEQ_MWAIT);
  endfunction

endpackage

// File: rtl/ysyx_23060061_exec_sequencer_watchdog.sv
// Bus watchdog: counts enabled cycles since the last clear, flags when the count hits TIMEOUT.
module ysyx_23060061_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned WD_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  logic [WD_W-1:0] count;

  assign expired_c = (TIMEOUT != 0) && enable && (count == WD_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired_c) begin
      count <= count + WD_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_23060061_exec_sequencer.sv
// Multi-cycle fetch/decode/memory/writeback control FSM with commit gating,
// cycle/instret counters and a bus watchdog.
module ysyx_23060061_exec_sequencer
  import ysyx_23060061_exec_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned WD_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  input  logic               ifu_rsp_valid,
  input  logic               ifu_rsp_err,
  output logic               inst_we,
  input  logic [MEMRW_W-1:0] dec_mem_rw,
  input  logic               dec_reg_write,
  input  logic               dec_ebreak,
  output logic               lsu_req_valid,
  input  logic               lsu_req_ready,
  input  logic               lsu_rsp_valid,
  input  logic               lsu_rsp_err,
  output logic               lsu_rdata_we,
  output logic               rf_we,
  output logic               pc_we,
  output logic               halted,
  output logic               fault,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  seqState_e state;
  seqState_e stateNext;
  logic      memRead;
  logic      wdExpired;

  ysyx_23060061_watchdog #(
    .TIMEOUT(TIMEOUT),
    .WD_W   (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (stateNext != state),
    .enable   (isBusWait(state)),
    .expired_c(wdExpired)
  );

  // Next-state and output decode; the watchdog overrides any other transition.
  always_comb begin
    stateNext     = state;
    ifu_req_valid = 1'b0;
    inst_we       = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_rdata_we  = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    case (state)
      SEQ_FETCH: begin
        // Reset parks the FSM in FETCH; keep the request quiet while reset is held.
        ifu_req_valid = rst_n;
        if (ifu_req_ready) stateNext = SEQ_IWAIT;
      end
      SEQ_IWAIT: begin
        if (ifu_rsp_valid) begin
          if (ifu_rsp_err) begin
            stateNext = SEQ_FAULT;
          end else begin
            inst_we   = !wdExpired;
            stateNext = SEQ_DECODE;
          end
        end
      end
      SEQ_DECODE: begin
        if (dec_ebreak)                  stateNext = SEQ_HALT;
        else if (dec_mem_rw == MEM_ILL)  stateNext = SEQ_FAULT;
        else if (dec_mem_rw != MEM_NONE) stateNext = SEQ_MREQ;
        else                             stateNext = SEQ_WB;
      end
      SEQ_MREQ: begin
        lsu_req_valid = 1'b1;
        if (lsu_req_ready) stateNext = SEQ_MWAIT;
      end
      SEQ_MWAIT: begin
        if (lsu_rsp_valid) begin
          if (lsu_rsp_err) begin
            stateNext = SEQ_FAULT;
          end else begin
            lsu_rdata_we = memRead && !wdExpired;
            stateNext    = SEQ_WB;
          end
        end
      end
      SEQ_WB: begin
        rf_we     = dec_reg_write;
        pc_we     = 1'b1;
        stateNext = SEQ_FETCH;
      end
      SEQ_HALT:  halted = 1'b1;
      SEQ_FAULT: fault  = 1'b1;
      default:   stateNext = SEQ_FAULT;
    endcase
    if (wdExpired) stateNext = SEQ_FAULT;
  end

  // State register, read/write flag captured at decode, and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SEQ_FETCH;
      memRead     <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state <= stateNext;
      if (state == SEQ_DECODE) memRead <= (dec_mem_rw == MEM_RD);
      if ((state != SEQ_HALT) && (state != SEQ_FAULT)) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state == SEQ_WB) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_exec_sequencer.sv
// Randomised scoreboard bench for the execution sequencer plus directed watchdog/error runs.
module tb_ysyx_23060061_exec_sequencer;
  import ysyx_23060061_exec_sequencer_pkg::*;

  localparam int unsigned CNT_A = 8;
  localparam int unsigned CNT_B = 16;
  localparam int unsigned MOD_A = 1 << CNT_A;

  logic clk = 1'b0;
  logic rst_n, rstB_n;
  logic ifuReqReady, ifuRspValid, ifuRspErr;
  logic lsuReqReady, lsuRspValid, lsuRspErr;
  logic [1:0] decMemRw;
  logic decRegWrite, decEbreak;

  logic aIfuReqValid, aInstWe, aLsuReqValid, aLsuRdataWe, aRfWe, aPcWe, aHalted, aFault;
  logic [CNT_A-1:0] aCycle, aInstret;
  logic bIfuReqValid, bInstWe, bLsuReqValid, bLsuRdataWe, bRfWe, bPcWe, bHalted, bFault;
  logic [CNT_B-1:0] bCycle, bInstret;

  always #5 clk = ~clk;

  ysyx_23060061_exec_sequencer #(.CNT_W(CNT_A), .TIMEOUT(255), .WD_W(8)) dutA (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(aIfuReqValid), .ifu_req_ready(ifuReqReady),
    .ifu_rsp_valid(ifuRspValid), .ifu_rsp_err(ifuRspErr), .inst_we(aInstWe),
    .dec_mem_rw(decMemRw), .dec_reg_write(decRegWrite), .dec_ebreak(decEbreak),
    .lsu_req_valid(aLsuReqValid), .lsu_req_ready(lsuReqReady),
    .lsu_rsp_valid(lsuRspValid), .lsu_rsp_err(lsuRspErr), .lsu_rdata_we(aLsuRdataWe),
    .rf_we(aRfWe), .pc_we(aPcWe), .halted(aHalted), .fault(aFault),
    .cycle_cnt(aCycle), .instret_cnt(aInstret)
  );

  ysyx_23060061_exec_sequencer #(.CNT_W(CNT_B), .TIMEOUT(8), .WD_W(4)) dutB (
    .clk(clk), .rst_n(rstB_n),
    .ifu_req_valid(bIfuReqValid), .ifu_req_ready(ifuReqReady),
    .ifu_rsp_valid(ifuRspValid), .ifu_rsp_err(ifuRspErr), .inst_we(bInstWe),
    .dec_mem_rw(decMemRw), .dec_reg_write(decRegWrite), .dec_ebreak(decEbreak),
    .lsu_req_valid(bLsuReqValid), .lsu_req_ready(lsuReqReady),
    .lsu_rsp_valid(lsuRspValid), .lsu_rsp_err(lsuRspErr), .lsu_rdata_we(bLsuRdataWe),
    .rf_we(bRfWe), .pc_we(bPcWe), .halted(bHalted), .fault(bFault),
    .cycle_cnt(bCycle), .instret_cnt(bInstret)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rfWe;
    int unsigned instret;
    int unsigned cyc;
    int unsigned ifuCycles;
    int unsigned lsuCycles;
    int unsigned rdPulses;
  } commit_t;

  commit_t     commitQ[$];
  int unsigned modelCycles, modelInstret, extraFetch;

  // Monitor: accumulates handshake activity and checks each commit against the scoreboard.
  int unsigned mIfu, mLsu, mRd, mInst;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      mIfu = 0; mLsu = 0; mRd = 0; mInst = 0;
    end else begin
      mIfu  += 32'(aIfuReqValid);
      mLsu  += 32'(aLsuReqValid);
      mRd   += 32'(aLsuRdataWe);
      mInst += 32'(aInstWe);
      chk("halt_fault_exclusive", 64'(aHalted & aFault), 64'd0);
      if (aPcWe) begin
        if (commitQ.size() == 0) begin
          chk("unexpected_commit", 64'(aPcWe), 64'd0);
        end else begin
          commit_t e;
          e = commitQ.pop_front();
          chk("commit_rf_we", 64'(aRfWe), 64'(e.rfWe));
          chk("commit_instret", 64'(aInstret), 64'(e.instret));
          chk("commit_cycle", 64'(aCycle), 64'(e.cyc));
          chk("ifu_valid_cycles", 64'(mIfu), 64'(e.ifuCycles));
          chk("lsu_valid_cycles", 64'(mLsu), 64'(e.lsuCycles));
          chk("rdata_we_pulses", 64'(mRd), 64'(e.rdPulses));
          chk("inst_we_pulses", 64'(mInst), 64'd1);
        end
        mIfu = 0; mLsu = 0; mRd = 0; mInst = 0;
      end
    end
  end

  task automatic idleInputs();
    ifuReqReady = 0; ifuRspValid = 0; ifuRspErr = 0;
    lsuReqReady = 0; lsuRspValid = 0; lsuRspErr = 0;
    decMemRw = MEM_NONE; decRegWrite = 0; decEbreak = 0;
  endtask

  task automatic chkIdleA(input string tag);
    chk({tag, "_ifu_req_valid"}, 64'(aIfuReqValid), 64'd0);
    chk({tag, "_outputs"}, 64'({aInstWe, aLsuReqValid, aLsuRdataWe, aRfWe, aPcWe, aHalted, aFault}), 64'd0);
    chk({tag, "_cycle"}, 64'(aCycle), 64'd0);
    chk({tag, "_instret"}, 64'(aInstret), 64'd0);
  endtask

  // Reset dutA with stale responses on the buses, then release at a falling edge.
  task automatic doReset();
    rst_n = 0;
    idleInputs();
    ifuRspValid = 1; lsuRspValid = 1;
    repeat (2) @(negedge clk);
    #1 chkIdleA("reset");
    @(negedge clk);
    idleInputs();
    rst_n = 1;
    modelCycles = 0; modelInstret = 0; extraFetch = 0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 ebreak, 4 illegal MemRW, 5 ebreak with MemRW=11
  // endMode: 0 normal, 1 LSU error response, 2 reset asserted on entering MWAIT
  task automatic doInstr(input int kind, input int unsigned dF, input int unsigned dR,
                         input int unsigned dM, input int unsigned dW,
                         input logic regWr, input int endMode);
    int n = 0;
    logic isMem;
    commit_t e;
    isMem = (kind == 1) || (kind == 2);
    if (kind <= 2 && endMode == 0) begin
      int unsigned total;
      total = dF + dR + 4 + (isMem ? dM + dW + 2 : 0);
      e.rfWe      = regWr;
      e.instret   = modelInstret % MOD_A;
      e.cyc       = (modelCycles + total - 1) % MOD_A;
      e.ifuCycles = dF + 1 + extraFetch;
      e.lsuCycles = isMem ? dM + 1 : 0;
      e.rdPulses  = (kind == 1) ? 1 : 0;
      commitQ.push_back(e);
      modelCycles  += total;
      modelInstret += 1;
    end else if (kind >= 3) begin
      modelCycles += dF + dR + 3;
    end
    extraFetch = 0;
    #1;
    while (!aIfuReqValid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n == 20) chk("fetch_wait_timeout", 64'(aIfuReqValid), 64'd1);
    for (int unsigned i = 0; i <= dF; i++) begin
      ifuReqReady = (i == dF);
      ifuRspValid = 1'($urandom); ifuRspErr = 1'($urandom);
      lsuRspValid = 1'($urandom); lsuRspErr = 1'($urandom);
      @(negedge clk); #1;
    end
    ifuReqReady = 0;
    for (int unsigned j = 0; j <= dR; j++) begin
      ifuRspValid = (j == dR);
      ifuRspErr   = (j == dR) ? 1'b0 : 1'($urandom);
      lsuRspValid = 1'($urandom); lsuRspErr = 1'($urandom);
      @(negedge clk); #1;
    end
    decEbreak   = (kind == 3) || (kind == 5);
    decMemRw    = (kind == 1) ? MEM_RD : (kind == 2) ? MEM_WR : (kind >= 4) ? MEM_ILL : MEM_NONE;
    decRegWrite = regWr;
    ifuRspValid = 1'($urandom); ifuRspErr = 1'($urandom);
    @(negedge clk); #1;
    if (kind >= 3) return;
    if (isMem) begin
      for (int unsigned k = 0; k <= dM; k++) begin
        lsuReqReady = (k == dM);
        lsuRspValid = 1'($urandom); lsuRspErr = 1'($urandom);
        ifuRspValid = 1'($urandom);
        @(negedge clk); #1;
      end
      lsuReqReady = 0;
      if (endMode == 2) begin
        rst_n = 0;
        lsuRspValid = 1;
        return;
      end
      for (int unsigned k = 0; k <= dW; k++) begin
        lsuRspValid = (k == dW);
        lsuRspErr   = (k == dW) ? (endMode == 1) : 1'($urandom);
        ifuRspValid = 1'($urandom);
        if (k == dW && endMode == 1) #1 chk("rdata_we_on_err", 64'(aLsuRdataWe), 64'd0);
        @(negedge clk); #1;
      end
      if (endMode == 1) return;
    end
    lsuRspValid = 1'($urandom); lsuRspErr = 1'($urandom);
    ifuRspValid = 1'($urandom);
    @(negedge clk);
    ifuRspValid = 0; lsuRspValid = 0;
  endtask

  task automatic bStart();
    rstB_n = 0;
    idleInputs();
    repeat (2) @(negedge clk);
    rstB_n = 1;
  endtask

  initial begin
    rst_n = 0; rstB_n = 0;
    idleInputs();
    modelCycles = 0; modelInstret = 0; extraFetch = 0;

    // addi with zero-wait buses
    doReset();
    doInstr(0, 0, 0, 0, 0, 1'b1, 0);
    #1 chk("t1_instret", 64'(aInstret), 64'd1);
    chk("t1_cycle", 64'(aCycle), 64'd4);

    // lw with LSU ready stalled 3 cycles, response 2 cycles after accept
    doInstr(1, 0, 0, 3, 1, 1'b1, 0);
    #1 chk("t2_cycle", 64'(aCycle), 64'd14);
    chk("t2_instret", 64'(aInstret), 64'd2);

    // sw without register write
    doInstr(2, 0, 0, 0, 0, 1'b0, 0);

    // random instruction mix with random handshake stalls and bus noise
    repeat (60) begin
      doInstr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 0);
    end

    // ebreak outranks an illegal MemRW; counters freeze (cycle_cnt has wrapped)
    doInstr(5, 1, 1, 0, 0, 1'b0, 0);
    #1 chk("prio_halted", 64'(aHalted), 64'd1);
    chk("prio_fault", 64'(aFault), 64'd0);
    chk("prio_instret", 64'(aInstret), 64'(modelInstret % MOD_A));
    repeat (4) begin
      @(negedge clk);
      #1 chk("prio_cycle_frozen", 64'(aCycle), 64'(modelCycles % MOD_A));
      chk("prio_no_fetch", 64'(aIfuReqValid), 64'd0);
    end

    // ebreak after three addi
    doReset();
    repeat (3) doInstr(0, 0, 0, 0, 0, 1'b1, 0);
    doInstr(3, 0, 0, 0, 0, 1'b0, 0);
    #1 chk("t4_halted", 64'(aHalted), 64'd1);
    chk("t4_instret", 64'(aInstret), 64'd3);
    repeat (3) begin
      @(negedge clk);
      #1 chk("t4_cycle", 64'(aCycle), 64'd15);
      chk("t4_no_fetch", 64'(aIfuReqValid), 64'd0);
    end

    // illegal MemRW
    doReset();
    doInstr(0, 0, 0, 0, 0, 1'b1, 0);
    doInstr(4, 0, 0, 0, 0, 1'b0, 0);
    #1 chk("ill_fault", 64'(aFault), 64'd1);
    chk("ill_halted", 64'(aHalted), 64'd0);
    chk("ill_cycle", 64'(aCycle), 64'd7);

    // LSU error on a load
    doReset();
    doInstr(1, 0, 0, 0, 0, 1'b1, 1);
    #1 chk("lsu_err_fault", 64'(aFault), 64'd1);
    chk("lsu_err_instret", 64'(aInstret), 64'd0);

    // reset in MWAIT, stale LSU response after release
    doReset();
    doInstr(1, 0, 0, 1, 0, 1'b1, 2);
    #1 chkIdleA("mid_reset");
    @(negedge clk);
    #1 chkIdleA("mid_reset_hold");
    @(negedge clk);
    rst_n = 1;
    lsuRspValid = 1; lsuRspErr = 0;
    #1 chk("rel_cycle", 64'(aCycle), 64'd0);
    chk("rel_fetch", 64'(aIfuReqValid), 64'd1);
    @(negedge clk);
    #1 chk("stale_rdata_we", 64'(aLsuRdataWe), 64'd0);
    chk("stale_lsu_req", 64'(aLsuReqValid), 64'd0);
    @(negedge clk);
    lsuRspValid = 0;
    modelCycles = 2; modelInstret = 0; extraFetch = 2;
    doInstr(0, 0, 0, 0, 0, 1'b1, 0);
    #1 chk("restart_instret", 64'(aInstret), 64'd1);

    // watchdog runs on dutB (TIMEOUT=8) while dutA is held in reset
    rst_n = 0;
    bStart();
    ifuReqReady = 1;
    @(negedge clk);
    ifuReqReady = 0;
    repeat (8) @(negedge clk);
    #1 chk("wd_iwait_before", 64'(bFault), 64'd0);
    @(negedge clk);
    #1 chk("wd_iwait_fault", 64'(bFault), 64'd1);
    chk("wd_iwait_cycle", 64'(bCycle), 64'd10);
    chk("wd_iwait_halted", 64'(bHalted), 64'd0);

    bStart();
    repeat (8) @(negedge clk);
    #1 chk("wd_fetch_before", 64'(bFault), 64'd0);
    chk("wd_fetch_valid", 64'(bIfuReqValid), 64'd1);
    @(negedge clk);
    #1 chk("wd_fetch_fault", 64'(bFault), 64'd1);
    chk("wd_fetch_no_valid", 64'(bIfuReqValid), 64'd0);

    bStart();
    ifuReqReady = 1;
    @(negedge clk);
    ifuReqReady = 0; ifuRspValid = 1; ifuRspErr = 1;
    #1 chk("ifu_err_inst_we", 64'(bInstWe), 64'd0);
    @(negedge clk);
    ifuRspValid = 0; ifuRspErr = 0;
    #1 chk("ifu_err_fault", 64'(bFault), 64'd1);
    chk("ifu_err_cycle", 64'(bCycle), 64'd2);

    // response one cycle before the watchdog limit is accepted
    bStart();
    ifuReqReady = 1;
    @(negedge clk);
    ifuReqReady = 0;
    repeat (7) @(negedge clk);
    ifuRspValid = 1;
    #1 chk("wd_edge_inst_we", 64'(bInstWe), 64'd1);
    @(negedge clk);
    ifuRspValid = 0; decEbreak = 1; decMemRw = MEM_NONE;
    #1 chk("wd_edge_no_fault", 64'(bFault), 64'd0);
    @(negedge clk);
    #1 chk("wd_edge_halted", 64'(bHalted), 64'd1);
    chk("wd_edge_cycle", 64'(bCycle), 64'd10);

    chk("scoreboard_drained", 64'(commitQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
